// File: rtl/pin_entry_ctrl.sv
// rtl/pin_entry_ctrl.sv - keypad debounce, BCD digit entry buffer and code check FSM
module pin_entry_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          MAX_TRIES       = 3,
  parameter logic [15:0] CODE            = 16'h2197
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  keys,
  input  logic        enter,
  input  logic        clear,
  output logic [15:0] digits,
  output logic [2:0]  digit_count,
  output logic        digit_strobe,
  output logic        unlocked,
  output logic        err_pulse,
  output logic        alarm,
  output logic [2:0]  tries
);

  typedef enum logic [1:0] {ENTRY, CHECK, UNLOCKED, ALARM} state_t;

  localparam logic [3:0] CNT_MAX    = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] CNT_STABLE = 4'(DEBOUNCE_CYCLES - 2);
  localparam logic [2:0] TRIES_MAX  = 3'(MAX_TRIES);

  state_t      state_q, state_d;
  logic [9:0]  prev_q, prev_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic [15:0] digits_q, digits_d;
  logic [2:0]  count_q, count_d;
  logic        strobe_q, strobe_d;
  logic        err_q, err_d;
  logic [2:0]  tries_q, tries_d;

  logic        stable;
  logic        onehot;
  logic        accept;
  logic [3:0]  bcd;
  logic [2:0]  tries_inc;

  always_comb begin
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    bcd     = 4'd0;

    if (keys != prev_q) begin
      prev_d = keys;
      cnt_d  = 4'd0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 4'd1;
    end

    // This edge is at least the DEBOUNCE_CYCLES-th identical sample of prev_q
    stable = (keys == prev_q) && (cnt_q >= CNT_STABLE);
    onehot = (prev_q != 10'd0) && ((prev_q & (prev_q - 10'd1)) == 10'd0);
    accept = stable && armed_q && onehot;

    for (int i = 0; i < 10; i++) begin
      if (prev_q[i]) bcd = 4'(i);
    end

    if (stable && (prev_q == 10'd0)) armed_d = 1'b1;
    if (accept) armed_d = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    count_d   = count_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    tries_d   = tries_q;
    tries_inc = tries_q + 3'd1;

    case (state_q)
      ENTRY: begin
        if (clear) begin
          digits_d = 16'd0;
          count_d  = 3'd0;
        end else if (enter) begin
          state_d = CHECK;
        end else if (accept && (count_q < 3'd4)) begin
          digits_d = {digits_q[11:0], bcd};
          count_d  = count_q + 3'd1;
          strobe_d = 1'b1;
        end
      end
      CHECK: begin
        digits_d = 16'd0;
        count_d  = 3'd0;
        if (count_q != 3'd4) begin
          err_d   = 1'b1;
          state_d = ENTRY;
        end else if (digits_q == CODE) begin
          tries_d = 3'd0;
          state_d = UNLOCKED;
        end else begin
          err_d   = 1'b1;
          tries_d = tries_inc;
          state_d = (tries_inc == TRIES_MAX) ? ALARM : ENTRY;
        end
      end
      UNLOCKED: begin
        if (clear) begin
          digits_d = 16'd0;
          count_d  = 3'd0;
          state_d  = ENTRY;
        end
      end
      ALARM: begin
        state_d = ALARM;
      end
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ENTRY;
      prev_q   <= 10'd0;
      cnt_q    <= 4'd0;
      armed_q  <= 1'b0;
      digits_q <= 16'd0;
      count_q  <= 3'd0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      tries_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      tries_q  <= tries_d;
    end
  end

  assign digits       = digits_q;
  assign digit_count  = count_q;
  assign digit_strobe = strobe_q;
  assign err_pulse    = err_q;
  assign tries        = tries_q;
  assign unlocked     = (state_q == UNLOCKED);
  assign alarm        = (state_q == ALARM);

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// tb/tb_pin_entry_ctrl.sv - directed self-checking bench for pin_entry_ctrl
module tb_pin_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  keys = 10'd0;
  logic        enter = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic        digit_strobe;
  logic        unlocked;
  logic        err_pulse;
  logic        alarm;
  logic [2:0]  tries;

  int n_checks = 0;
  int n_pass   = 0;
  int strobes  = 0;

  pin_entry_ctrl #(.DEBOUNCE_CYCLES(4), .MAX_TRIES(3), .CODE(16'h2197)) dut (
    .clk(clk), .rst(rst), .keys(keys), .enter(enter), .clear(clear),
    .digits(digits), .digit_count(digit_count), .digit_strobe(digit_strobe),
    .unlocked(unlocked), .err_pulse(err_pulse), .alarm(alarm), .tries(tries)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (digit_strobe) strobes++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int k);
    keys = 10'd1 << k;
    tick(6);
    keys = 10'd0;
    tick(6);
  endtask

  task automatic pulse_enter();
    enter = 1'b1;
    tick(1);
    enter = 1'b0;
    tick(1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  initial begin
    // 1: reset state and single-digit latency
    tick(2);
    rst = 1'b0;
    check("rst_digits", digits, 0);
    check("rst_count", digit_count, 0);
    check("rst_flags", {digit_strobe, unlocked, err_pulse, alarm}, 0);
    check("rst_tries", tries, 0);
    tick(6);
    strobes = 0;
    keys = 10'b0000000100;
    tick(3);
    check("t1_no_early_strobe", digit_strobe, 0);
    tick(1);
    check("t1_strobe_4th_edge", digit_strobe, 1);
    tick(2);
    keys = 10'd0;
    tick(6);
    check("t1_one_strobe", strobes, 1);
    check("t1_digits", digits, 16'h0002);
    check("t1_count", digit_count, 1);

    // 2: correct code unlocks, clear relocks
    pulse_clear();
    check("t2_cleared", digit_count, 0);
    press(2); press(1); press(9); press(7);
    check("t2_buffer", digits, 16'h2197);
    check("t2_count4", digit_count, 4);
    pulse_enter();
    check("t2_unlocked", unlocked, 1);
    check("t2_no_err", err_pulse, 0);
    check("t2_tries", tries, 0);
    check("t2_digits_zero", digits, 0);
    press(3);
    check("t2_keys_ignored", digit_count, 0);
    pulse_clear();
    tick(1);
    check("t2_relocked", unlocked, 0);

    // 3: bounce and multi-key rejection
    strobes = 0;
    keys = 10'd1 << 5; tick(1);
    keys = 10'd0;      tick(1);
    keys = 10'd1 << 5; tick(1);
    keys = 10'd0;      tick(1);
    keys = 10'd1 << 5; tick(6);
    keys = 10'd0;      tick(6);
    check("t3_one_strobe", strobes, 1);
    check("t3_digit5", digits[3:0], 5);
    keys = 10'b0000011000;
    tick(10);
    keys = 10'd0;
    tick(6);
    check("t3_multi_ignored", strobes, 1);
    check("t3_count", digit_count, 1);
    pulse_clear();

    // 4: three wrong attempts lead to alarm
    for (int a = 1; a <= 3; a++) begin
      press(1); press(2); press(3); press(4);
      pulse_enter();
      check($sformatf("t4_err_%0d", a), err_pulse, 1);
      check($sformatf("t4_tries_%0d", a), tries, a);
      check($sformatf("t4_alarm_%0d", a), alarm, (a == 3) ? 1 : 0);
    end
    strobes = 0;
    press(2);
    pulse_clear();
    pulse_enter();
    tick(2);
    check("t4_alarm_held", alarm, 1);
    check("t4_tries_held", tries, 3);
    check("t4_no_entry", {strobes[3:0], 1'b0, digit_count}, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t4_rst_outputs", {digits, digit_count, digit_strobe, unlocked, err_pulse, alarm, tries}, 0);

    // 5: short entry and fifth-digit drop
    tick(6);
    press(2); press(1);
    pulse_enter();
    check("t5_short_err", err_pulse, 1);
    check("t5_short_tries", tries, 0);
    check("t5_short_count", digit_count, 0);
    strobes = 0;
    press(2); press(1); press(9); press(7); press(8);
    check("t5_fifth_dropped", digits, 16'h2197);
    check("t5_count4", digit_count, 4);
    check("t5_four_strobes", strobes, 4);
    pulse_clear();

    // 6: clear beats enter; reset during CHECK
    press(1); press(2); press(3);
    check("t6_count3", digit_count, 3);
    clear = 1'b1;
    enter = 1'b1;
    tick(1);
    clear = 1'b0;
    enter = 1'b0;
    check("t6_cleared", {digits, 1'b0, digit_count}, 0);
    tick(1);
    check("t6_no_err", {err_pulse, unlocked, alarm}, 0);
    press(4);
    check("t6_still_entry", digits, 16'h0004);
    enter = 1'b1;
    tick(1);
    enter = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_rst_in_check", {digits, digit_count, err_pulse, unlocked, alarm, tries}, 0);
    tick(1);
    check("t6_no_late_err", err_pulse, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pin_entry_ctrl.md
Name: pin_entry_ctrl

Overview:
Keypad digit-entry and code-check controller for the keypad lock datapath.
- Accepts raw 10-line keypad input and debounces it.
- Converts each accepted key press to BCD and shifts it into a 4-digit entry buffer.
- On `enter`, compares the buffer against a stored code and drives unlock, error and alarm status.
- Provides the one-hot-to-BCD conversion and digit storage consumed by the display and shift-register stages.

Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive identical samples (range 2..15) required to accept a pattern.
- MAX_TRIES, 3, number of failed full-length attempts before alarm (range 1..7).
- CODE, 16'h2197, stored 4-digit BCD code; most-significant nibble is the first digit entered.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- keys  input  10  raw key lines; keys[n] high = key n pressed
- enter  input  1  level; sampled per cycle, submit entry
- clear  input  1  level; sampled per cycle, discard entry / relock
- digits  output  16  entry buffer, 4 BCD nibbles, newest digit in [3:0]
- digit_count  output  3  digits held, 0..4
- digit_strobe  output  1  one-cycle pulse per accepted digit
- unlocked  output  1  high while in state UNLOCKED
- err_pulse  output  1  one-cycle pulse on rejected entry
- alarm  output  1  high while in state ALARM
- tries  output  3  failed full-length attempts so far

Behaviour:
Reset and clocking:
- One clock. Reset is synchronous and active-high; both ports are named as the codebase does (`clk`, `rst`).
- Reset values: digits=0, digit_count=0, digit_strobe=0, unlocked=0, err_pulse=0, alarm=0, tries=0, state=ENTRY, debounce counter=0, sampled pattern=0, armed=0.
- Reset mid-operation, including from ALARM, returns every register to its reset value on that edge.

Debounce (runs in every state):
- A registered copy `prev` of `keys` and a counter `cnt` are maintained.
- If keys≠prev: prev<=keys, cnt<=0.
- Otherwise cnt increments, saturating at DEBOUNCE_CYCLES-1.
- A pattern is stable when sampled identical on DEBOUNCE_CYCLES consecutive edges.
- Stable pattern 0 sets `armed`.
- A stable pattern with exactly one bit set, while armed, is an accept event on that edge; `armed` clears.
- Stable multi-bit patterns are ignored and do not set `armed`.
- A held key produces exactly one accept. A new accept requires a stable all-zero pattern first.

Accept handling:
- An accept acts only in state ENTRY and only when enter=0 and clear=0.
- In the cycle after the accepting edge: digits={digits[11:0], bcd(n)}, digit_count+1, digit_strobe=1 for one cycle.
- If digit_count==4, the accept is dropped: no strobe, buffer unchanged.

State machine (ENTRY, CHECK, UNLOCKED, ALARM):
- ENTRY, clear=1: digits<=0, digit_count<=0; tries unchanged.
- ENTRY, enter=1 (clear=0): go to CHECK.
- CHECK lasts one cycle.
  - digit_count<4: err_pulse, clear buffer, tries unchanged, back to ENTRY.
  - digits==CODE: go to UNLOCKED, clear buffer, tries<=0.
  - Mismatch: err_pulse, clear buffer, tries+1. Go to ALARM if the new tries==MAX_TRIES, else ENTRY.
- Latency: with enter sampled at edge N, unlocked, err_pulse or alarm is visible after edge N+1.
- UNLOCKED: keys and enter are ignored. clear=1 returns to ENTRY with the buffer cleared.
- ALARM: every input except rst is ignored.

Simultaneous events:
- clear beats enter.
- enter beats a same-edge accept; the accept is discarded.
- The debounce pipeline keeps running during CHECK, UNLOCKED and ALARM, but accepts made there are discarded.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset, hold keys=0 for 6 cycles; press key 2 (keys=10'b0000000100) for 6 cycles; release for 6 cycles -> one digit_strobe, 4 edges after the press is first sampled; digits=16'h0002, digit_count=1.
2. Enter 2,1,9,7, each held 6 cycles with 6-cycle gaps, then pulse enter -> after 2 edges unlocked=1, tries=0, digits=0. Pulse clear -> state ENTRY, unlocked=0.
3. Key bounce: key 5 toggled 1/0/1 on alternate cycles, then held 6 cycles -> exactly one strobe, digit 5. Keys 3 and 4 pressed together for 10 cycles -> no strobe.
4. Enter 1,2,3,4 and submit, three times -> err_pulse each time; tries goes 1, 2, 3. alarm=1 after the third attempt. Further keys, clear and enter have no effect; rst -> all outputs 0.
5. Enter 2,1 then enter -> err_pulse, tries stays 0, digit_count=0. Enter 5 digits 2,1,9,7,8 -> 5th dropped, digits=16'h2197.
6. clear and enter asserted in the same cycle with 3 digits held -> buffer cleared, no err_pulse, state remains ENTRY. rst asserted during CHECK -> reset values on the next edge.
